// File: rtl/alu_tx_pkg.sv
// Shared types and constants for the ALU result UART transmitter.
// ALU_TX_PARITY_EN adds a PARITY state to each frame when defined.
package alu_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        PARITY,
        STOP_BIT
    } tx_state_t;

    localparam int FRAME_BYTES = 2;
    localparam logic [4:0] FLAG_PAD = 5'b00000;

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// Request and status bundle between the ALU block and the UART transmitter.
interface alu_result_uart_tx_if;

    logic       start;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start, result, zero, carry, overflow,
        input  tx, busy, done
    );

    modport slave (
        input  start, result, zero, carry, overflow,
        output tx, busy, done
    );

endinterface

// File: rtl/alu_result_uart_tx_baud_tick.sv
// Baud-period counter: tick is high in the last cycle of each bit period.
module baud_tick #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = !clear && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Sends ALU result then flag byte as two back-to-back UART frames.
// Define ALU_TX_PARITY_EN to append an even-parity bit to every frame.
module alu_result_uart_tx
    import alu_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               rst,
    alu_result_uart_tx_if.slave bus
);

    localparam logic LAST_BYTE = 1'(FRAME_BYTES - 1);

    tx_state_t  state;
    logic       tick;
    logic       clear;
    logic       byte_idx;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic [7:0] byte1;
    logic       tx_q;
    logic       busy_q;
    logic       done_q;
`ifdef ALU_TX_PARITY_EN
    logic       par;
`endif

    // Holding the counter cleared in IDLE makes the start bit a full period.
    assign clear = (state == IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_idx <= 1'b0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            byte1    <= 8'h00;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    // A start coinciding with the done pulse is dropped.
                    if (bus.start && !done_q) begin
                        shreg    <= bus.result;
                        byte1    <= {FLAG_PAD, bus.overflow,
                                     bus.carry, bus.zero};
                        byte_idx <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START_BIT;
                    end
                end
                START_BIT: begin
                    tx_q <= 1'b0;
                    if (tick) begin
                        bit_idx <= 3'd0;
`ifdef ALU_TX_PARITY_EN
                        par     <= 1'b0;
`endif
                        state   <= DATA;
                    end
                end
                DATA: begin
                    tx_q <= shreg[0];
                    if (tick) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
`ifdef ALU_TX_PARITY_EN
                        par     <= par ^ shreg[0];
                        if (bit_idx == 3'd7) state <= PARITY;
`else
                        if (bit_idx == 3'd7) state <= STOP_BIT;
`endif
                    end
                end
`ifdef ALU_TX_PARITY_EN
                PARITY: begin
                    tx_q <= par;
                    if (tick) state <= STOP_BIT;
                end
`endif
                STOP_BIT: begin
                    tx_q <= 1'b1;
                    if (tick) begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= 1'b1;
                            shreg    <= byte1;
                            state    <= START_BIT;
                        end else begin
                            byte_idx <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
